// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg : opcodes, shift controls and data width shared by the ALU   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package alu_pkg;
   localparam int DATA_W = 32;

   localparam logic [3:0] ALU_XOR   = 4'b0000;
   localparam logic [3:0] ALU_AND   = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_NEG   = 4'b0011;
   localparam logic [3:0] ALU_SHIFT = 4'b0100;
   localparam logic [3:0] ALU_SUB   = 4'b0101;
   localparam logic [3:0] ALU_OR    = 4'b0110;

   localparam logic SHIFT_LEFT    = 1'b0;
   localparam logic SHIFT_RIGHT   = 1'b1;
   localparam logic SHIFT_LOGICAL = 1'b0;
   localparam logic SHIFT_ARITH   = 1'b1;
endpackage
`default_nettype wire

// File: rtl/alu_logic_block_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_logic_block_if : operand/control inputs and result/flag outputs  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface alu_logic_block_if;
   import alu_pkg::*;

   logic [DATA_W-1:0] A;
   logic [DATA_W-1:0] B;
   logic              shiftDir;
   logic              shiftOp;
   logic [3:0]        ALUctrlOP;
   logic              flagEn;
   logic [DATA_W-1:0] ALUres;
   logic              zeroFlag;
   logic              signFlag;
   logic              carryFlag;
   logic              overflow;

   modport master (
      output A, B, shiftDir, shiftOp, ALUctrlOP, flagEn,
      input  ALUres, zeroFlag, signFlag, carryFlag, overflow
   );

   modport slave (
      input  A, B, shiftDir, shiftOp, ALUctrlOP, flagEn,
      output ALUres, zeroFlag, signFlag, carryFlag, overflow
   );
endinterface
`default_nettype wire

// File: rtl/alu_barrel_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_barrel_shifter : 5-stage logarithmic left/right shifter          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_barrel_shifter
   import alu_pkg::*;
(
   input  wire logic [DATA_W-1:0] a,
   input  wire logic [4:0]        shamt,
   input  wire logic              dir,
   input  wire logic              arith,
   output      logic [DATA_W-1:0] result
);
   logic [DATA_W-1:0] w_stage [0:5];
   logic              w_fill;

   // Left shifts ignore arith: vacated low bits are always zero.
   assign w_fill     = (arith == SHIFT_ARITH) & a[DATA_W-1];
   assign w_stage[0] = a;

   for (genvar k = 0; k < 5; k++) begin : g_stage
      localparam int SH = 1 << k;
      assign w_stage[k+1] = !shamt[k]           ? w_stage[k] :
                            (dir == SHIFT_RIGHT) ? {{SH{w_fill}}, w_stage[k][DATA_W-1:SH]} :
                                                   {w_stage[k][DATA_W-1-SH:0], {SH{1'b0}}};
   end

   assign result = w_stage[5];
endmodule
`default_nettype wire

// File: rtl/alu_logic_block.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_logic_block : combinational 32-bit ALU with registered flags     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_logic_block
   import alu_pkg::*;
(
   input wire logic          clk,
   input wire logic          rst,
   alu_logic_block_if.slave  bus
);
   logic [DATA_W-1:0] w_opA;
   logic [DATA_W-1:0] w_opB;
   logic              w_cin;
   logic [DATA_W:0]   w_sum;
   logic [DATA_W-1:0] w_shift;
   logic [DATA_W-1:0] w_res;
   logic              w_isArith;
   logic              w_carry;
   logic              w_ovf;

   logic              r_zero;
   logic              r_sign;
   logic              r_carry;
   logic              r_ovf;

   alu_barrel_shifter u_shifter (
      .a      (bus.A),
      .shamt  (bus.B[4:0]),
      .dir    (bus.shiftDir),
      .arith  (bus.shiftOp),
      .result (w_shift)
   );

   // One adder serves ADD (A+B), SUB (A+~B+1) and NEG (~A+0+1).
   always_comb begin
      w_opA = bus.A;
      w_opB = bus.B;
      w_cin = 1'b0;
      case (bus.ALUctrlOP)
         ALU_SUB: begin
            w_opB = ~bus.B;
            w_cin = 1'b1;
         end
         ALU_NEG: begin
            w_opA = ~bus.A;
            w_opB = '0;
            w_cin = 1'b1;
         end
         default: ;
      endcase
   end

   assign w_sum = {1'b0, w_opA} + {1'b0, w_opB} + {{DATA_W{1'b0}}, w_cin};

   always_comb begin
      w_res = '0;
      case (bus.ALUctrlOP)
         ALU_XOR:                   w_res = bus.A ^ bus.B;
         ALU_AND:                   w_res = bus.A & bus.B;
         ALU_OR:                    w_res = bus.A | bus.B;
         ALU_SHIFT:                 w_res = w_shift;
         ALU_ADD, ALU_SUB, ALU_NEG: w_res = w_sum[DATA_W-1:0];
         default:                   w_res = '0;
      endcase
   end

   assign w_isArith = (bus.ALUctrlOP == ALU_ADD) || (bus.ALUctrlOP == ALU_SUB) ||
                      (bus.ALUctrlOP == ALU_NEG);
   assign w_carry   = w_isArith & w_sum[DATA_W];
   // Overflow from the actual adder operands covers ADD, SUB and NEG alike.
   assign w_ovf     = w_isArith & (w_opA[DATA_W-1] == w_opB[DATA_W-1]) &
                      (w_sum[DATA_W-1] != w_opA[DATA_W-1]);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_zero  <= 1'b0;
         r_sign  <= 1'b0;
         r_carry <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (bus.flagEn) begin
         r_zero  <= (w_res == '0);
         r_sign  <= w_res[DATA_W-1];
         r_carry <= w_carry;
         r_ovf   <= w_ovf;
      end
   end

   assign bus.ALUres    = w_res;
   assign bus.zeroFlag  = r_zero;
   assign bus.signFlag  = r_sign;
   assign bus.carryFlag = r_carry;
   assign bus.overflow  = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_alu_logic_block.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_logic_block : directed and random checks against a ref model  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_alu_logic_block;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nVec = 0;
   int   nErr = 0;

   logic expZero, expSign, expCarry, expOvf;

   alu_logic_block_if bus ();

   alu_logic_block dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nVec++;
      if (got !== exp) begin
         nErr++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic straight from the operation rules.
   function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic dir, input logic sop,
                                 output logic [31:0] res, output logic c, output logic v);
      longint ss;
      int     sh;
      c   = 1'b0;
      v   = 1'b0;
      res = '0;
      sh  = int'(b % 32);
      case (op)
         4'd0: res = a ^ b;
         4'd1: res = a & b;
         4'd6: res = a | b;
         4'd2: begin
            res = a + b;
            c   = (longint'(a) + longint'(b)) > 64'sd4294967295;
            ss  = longint'($signed(a)) + longint'($signed(b));
            v   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
         end
         4'd3: begin
            res = 32'd0 - a;
            c   = (a == 32'd0);
            v   = (a == 32'h8000_0000);
         end
         4'd5: begin
            res = a - b;
            c   = (a >= b);
            ss  = longint'($signed(a)) - longint'($signed(b));
            v   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
         end
         4'd4: begin
            if (dir == SHIFT_LEFT)         res = a << sh;
            else if (sop == SHIFT_LOGICAL) res = a >> sh;
            else                           res = $unsigned($signed(a) >>> sh);
         end
         default: res = '0;
      endcase
   endfunction

   // Drive one op, check ALUres (model and optional literal), clock, check flags.
   task automatic step(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic dir, input logic sop,
                       input logic en, input logic useLit, input logic [31:0] litRes);
      logic [31:0] mRes;
      logic        mC, mV;
      bus.ALUctrlOP = op;
      bus.A         = a;
      bus.B         = b;
      bus.shiftDir  = dir;
      bus.shiftOp   = sop;
      bus.flagEn    = en;
      model(op, a, b, dir, sop, mRes, mC, mV);
      #1;
      check_eq({tag, "_res"}, bus.ALUres, mRes);
      if (useLit) check_eq({tag, "_lit"}, bus.ALUres, litRes);
      @(posedge clk);
      if (rst) begin
         {expZero, expSign, expCarry, expOvf} = 4'b0000;
      end else if (en) begin
         expZero  = (mRes == 32'd0);
         expSign  = mRes[31];
         expCarry = mC;
         expOvf   = mV;
      end
      #1;
      check_eq({tag, "_zero"},  {31'd0, bus.zeroFlag},  {31'd0, expZero});
      check_eq({tag, "_sign"},  {31'd0, bus.signFlag},  {31'd0, expSign});
      check_eq({tag, "_carry"}, {31'd0, bus.carryFlag}, {31'd0, expCarry});
      check_eq({tag, "_ovf"},   {31'd0, bus.overflow},  {31'd0, expOvf});
   endtask

   initial begin
      {expZero, expSign, expCarry, expOvf} = 4'b0000;
      rst = 1'b1;
      step("rst", ALU_ADD, 32'd1, 32'd2, 1'b0, 1'b0, 1'b1, 1'b1, 32'd3);
      step("rst2", ALU_XOR, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
      rst = 1'b0;

      step("xor", ALU_XOR, 32'd7,  32'd19, 1'b0, 1'b0, 1'b0, 1'b1, 32'd20);
      step("and", ALU_AND, 32'd13, 32'd17, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1);
      step("or",  ALU_OR,  32'd12, 32'd3,  1'b0, 1'b0, 1'b0, 1'b1, 32'd15);
      step("add", ALU_ADD, 32'd243, 32'd117, 1'b0, 1'b0, 1'b1, 1'b1, 32'd360);
      check_eq("add_flags", {28'd0, bus.zeroFlag, bus.signFlag, bus.carryFlag, bus.overflow}, 32'd0);
      step("neg", ALU_NEG, 32'd243, 32'd5, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FF0D);
      check_eq("neg_sc", {30'd0, bus.signFlag, bus.carryFlag}, 32'b10);

      step("shl",  ALU_SHIFT, 32'd2, 32'd3, SHIFT_LEFT, 1'b0, 1'b1, 1'b1, 32'd16);
      step("shr",  ALU_SHIFT, 32'hFFFF_FF0D, 32'd3, SHIFT_RIGHT, SHIFT_LOGICAL, 1'b1, 1'b1, 32'h1FFF_FFE1);
      step("sra",  ALU_SHIFT, 32'hFFFF_FF0D, 32'd3, SHIFT_RIGHT, SHIFT_ARITH, 1'b1, 1'b1, 32'hFFFF_FFE1);
      step("shr32", ALU_SHIFT, 32'd32, 32'd3, SHIFT_RIGHT, SHIFT_LOGICAL, 1'b0, 1'b1, 32'd4);
      step("sra32", ALU_SHIFT, 32'd32, 32'd3, SHIFT_RIGHT, SHIFT_ARITH, 1'b0, 1'b1, 32'd4);
      step("shb23", ALU_SHIFT, 32'hFFFF_FF0D, 32'h23, SHIFT_RIGHT, SHIFT_ARITH, 1'b0, 1'b1, 32'hFFFF_FFE1);
      step("shl_a", ALU_SHIFT, 32'h8000_0001, 32'd1, SHIFT_LEFT, SHIFT_ARITH, 1'b0, 1'b1, 32'h0000_0002);
      step("sh0",  ALU_SHIFT, 32'h8765_4321, 32'd0, SHIFT_RIGHT, SHIFT_ARITH, 1'b0, 1'b1, 32'h8765_4321);

      step("ovf", ALU_ADD, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0000);
      check_eq("ovf_flags", {28'd0, bus.zeroFlag, bus.signFlag, bus.carryFlag, bus.overflow}, 32'b0101);
      step("wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0);
      check_eq("wrap_flags", {28'd0, bus.zeroFlag, bus.signFlag, bus.carryFlag, bus.overflow}, 32'b1010);
      step("sub0", ALU_SUB, 32'd5, 32'd5, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0);
      check_eq("sub0_zc", {30'd0, bus.zeroFlag, bus.carryFlag}, 32'b11);
      step("negmin", ALU_NEG, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0000);
      check_eq("negmin_v", {31'd0, bus.overflow}, 32'd1);
      step("neg0", ALU_NEG, 32'd0, 32'd9, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0);
      check_eq("neg0_c", {31'd0, bus.carryFlag}, 32'd1);

      rst = 1'b1;
      step("rstwin", ALU_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0);
      rst = 1'b0;
      step("set", ALU_ADD, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
      step("hold1", ALU_SUB, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      step("hold2", 4'b1010, 32'h1234, 32'h5678, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
      check_eq("hold_flags", {28'd0, bus.zeroFlag, bus.signFlag, bus.carryFlag, bus.overflow}, 32'b0101);

      for (int i = 0; i < 400; i++) begin
         logic [3:0]  op;
         logic [31:0] a, b;
         op  = (i % 5 == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
         a   = $urandom;
         b   = $urandom;
         if (i % 7 == 0) b = a;
         if (i % 11 == 0) a = 32'h8000_0000 | (a & 32'h1);
         rst = ($urandom_range(0, 19) == 0);
         step("rnd", op, a, b, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 32'd0);
      end
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/alu_logic_block.md
# alu_logic_block

32-bit integer ALU for the single-cycle RISC datapath, sitting between the register-file read ports and the writeback/branch logic. It computes XOR, AND, OR, ADD, SUB, two's-complement negate and barrel shifts combinationally. It also holds a clocked status-flag register (zero, sign, carry, overflow) that the branch unit reads.

## Interface
- Parameters: none; data width fixed at 32.
- clk  input  1  system clock; flag register updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- A  input  32  operand A (rs).
- B  input  32  operand B (rt or immediate); B[4:0] is the shift amount for shifts.
- shiftDir  input  1  0 = left, 1 = right.
- shiftOp  input  1  0 = logical, 1 = arithmetic.
- ALUctrlOP  input  4  operation select.
- flagEn  input  1  1 = capture flags of current op at next rising edge.
- ALUres  output  32  combinational result.
- zeroFlag  output  1  registered: last captured result == 0.
- signFlag  output  1  registered: last captured result[31].
- carryFlag  output  1  registered: carry-out of last captured arithmetic op.
- overflow  output  1  registered: signed overflow of last captured arithmetic op.

## Operation
- 0000 XOR: A ^ B.
- 0001 AND: A & B.
- 0010 ADD: A + B. Carry = bit 32 of the 33-bit sum. Overflow = (A[31]==B[31]) && (res[31]!=A[31]).
- 0011 NEG: ~A + 1; B ignored. Carry = 1 only when A == 0. Overflow = 1 only when A == 32'h8000_0000.
- 0100 SHIFT, shamt = B[4:0]; B[31:5] ignored:
  - shiftDir=0: A << shamt, regardless of shiftOp (arithmetic left = logical left).
  - shiftDir=1, shiftOp=0: A >> shamt, zero fill.
  - shiftDir=1, shiftOp=1: A >>> shamt, sign fill from A[31].
  - shamt = 0 passes A unchanged.
- 0101 SUB: A + ~B + 1. Carry = bit 32 (1 = no borrow). Overflow = (A[31]!=B[31]) && (res[31]!=A[31]).
- 0110 OR: A | B.
- 0111–1111 reserved: ALUres = 0.
- Non-arithmetic ops (XOR, AND, OR, SHIFT, reserved) produce carry = 0 and overflow = 0 candidates.
- Zero and sign candidates always come from ALUres.

## Timing
- ALUres: purely combinational from A, B, shiftDir, shiftOp, ALUctrlOP. Zero-cycle latency, valid in the same cycle.
- Flag register: on rising clk, if rst, all four flags <= 0. Otherwise, if flagEn, flags <= candidates of the current op. Otherwise flags hold.
- Reset value of every registered output is 0. ALUres is not affected by rst.
- rst and flagEn both high: rst wins.
- Flags read in cycle N reflect the op presented in the last cycle < N with flagEn=1.
- No handshake; inputs are sampled continuously.

## Structure
- Shared package (alu_pkg):
  - 4-bit opcode localparams: ALU_XOR, ALU_AND, ALU_ADD, ALU_NEG, ALU_SHIFT, ALU_SUB, ALU_OR.
  - SHIFT_LEFT/RIGHT and SHIFT_LOGICAL/ARITH constants.
  - Data width constant 32.
- One natural sub-module: alu_barrel_shifter (A, shamt, dir, arith -> result), 5-stage log shifter.
- A single 33-bit adder is shared by ADD, SUB and NEG, with muxed operands and carry-in.

## Test plan
- Logic ops, combinational: XOR A=7,B=19 -> ALUres=20; AND A=13,B=17 -> 1; OR A=12,B=3 -> 15.
- ADD A=243,B=117 -> 360. Then clock with flagEn=1 -> all four flags 0. NEG A=243 -> 32'hFFFF_FF0D; flags captured -> sign=1, carry=0.
- Shifts:
  - A=2,B=3,dir=0 -> 16.
  - A=32'hFFFF_FF0D,B=3,dir=1,op=0 -> 32'h1FFF_FFE1 (536870881).
  - Same with op=1 -> 32'hFFFF_FFE1.
  - A=32,B=3,dir=1 -> 4 for either op.
  - B=32'h23 -> shamt 3.
- Arithmetic flags:
  - 32'h7FFF_FFFF+1 -> 32'h8000_0000, overflow=1, sign=1, carry=0.
  - 32'hFFFF_FFFF+1 -> 0, zero=1, carry=1.
  - SUB 5-5 -> 0, zero=1, carry=1.
- Reset/hold:
  - Flags set, then rst=1 with flagEn=1 for one edge -> all flags 0.
  - Then flagEn=0 with changing ops -> flags hold.
  - Reserved opcode 1010 -> ALUres=0.
